// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the E stage and the multiply/divide unit.
// The E stage is the master; the unit itself is the slave.
interface mult_div_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (output start, op, A, B, input busy, HI, LO);
   modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning the HI/LO registers.
// The result is computed at issue and held pending until the cycle count expires.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   mult_div_unit_if.slave   md
);
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [31:0]     hi_reg, hi_next;
   logic [31:0]     lo_reg, lo_next;
   logic [63:0]     pend_reg, pend_next;
   logic            pend_valid_reg, pend_valid_next;

   logic [63:0]     prod_s, prod_u, result;
   logic            a_neg, b_neg, b_zero;
   logic [31:0]     a_mag, b_mag, b_mag_safe, q_mag, r_mag, quo, rem;

   // Division runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no special case.
   always_comb begin
      prod_s     = {{32{md.A[31]}}, md.A} * {{32{md.B[31]}}, md.B};
      prod_u     = {32'd0, md.A} * {32'd0, md.B};
      a_neg      = (md.op == OP_DIV) && md.A[31];
      b_neg      = (md.op == OP_DIV) && md.B[31];
      a_mag      = a_neg ? (~md.A + 32'd1) : md.A;
      b_mag      = b_neg ? (~md.B + 32'd1) : md.B;
      b_zero     = (md.B == 32'd0);
      b_mag_safe = b_zero ? 32'd1 : b_mag;
      q_mag      = a_mag / b_mag_safe;
      r_mag      = a_mag % b_mag_safe;
      quo        = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      rem        = a_neg ? (~r_mag + 32'd1) : r_mag;
      case (md.op)
         OP_MULT:  result = prod_s;
         OP_MULTU: result = prod_u;
         default:  result = {rem, quo};
      endcase
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      hi_next         = hi_reg;
      lo_next         = lo_reg;
      pend_next       = pend_reg;
      pend_valid_next = pend_valid_reg;
      case (state_reg)
         IDLE: begin
            if (md.start) begin
               case (md.op)
                  OP_MULT, OP_MULTU: begin
                     pend_next       = result;
                     pend_valid_next = 1'b1;
                     cnt_next        = CW'(MULT_CYCLES);
                     state_next      = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     // A zero divisor still occupies the unit but leaves HI/LO untouched.
                     pend_next       = result;
                     pend_valid_next = !b_zero;
                     cnt_next        = CW'(DIV_CYCLES);
                     state_next      = RUN;
                  end
                  OP_MTHI: hi_next = md.A;
                  OP_MTLO: lo_next = md.A;
                  default: ;
               endcase
            end
         end
         RUN: begin
            cnt_next = cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
               state_next = IDLE;
               if (pend_valid_reg) begin
                  hi_next = pend_reg[63:32];
                  lo_next = pend_reg[31:0];
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         hi_reg         <= '0;
         lo_reg         <= '0;
         pend_reg       <= '0;
         pend_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         hi_reg         <= hi_next;
         lo_reg         <= lo_next;
         pend_reg       <= pend_next;
         pend_valid_reg <= pend_valid_next;
      end
   end

   assign md.busy = (state_reg == RUN);
   assign md.HI   = hi_reg;
   assign md.LO   = lo_reg;
endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. Executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo` against private HI/LO registers. Drives `busy`, which the hazard unit combines with `start` to stall any HI/LO-touching instruction held in D. It is the producer of the multi-cycle stall condition that the hazard unit consumes.

## Interface
- `MULT_CYCLES`, 5: busy cycles for `mult`/`multu` (≥1).
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu` (≥1).
- `clk` input 1: single clock. All state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: qualifies `op` for one cycle (the E-stage instruction is an MD op).
- `op` input 3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved.
- `A` input 32: rs operand (forwarded E value).
- `B` input 32: rt operand (forwarded E value).
- `busy` output 1: an operation is in flight.
- `HI` output 32: architectural HI register.
- `LO` output 32: architectural LO register.

## Operation
- Registers: `HI` and `LO`, pending result `hi_nx`/`lo_nx` (64 bits), down-counter `cnt` (width ≥ clog2(max(MULT_CYCLES, DIV_CYCLES)+1)), `busy`.
- Reset, synchronous: `HI=0`, `LO=0`, `busy=0`, `cnt=0`, pending result cleared. Any in-flight operation is discarded.
- States: IDLE (`busy=0`) and RUN (`busy=1`).
- IDLE, `start=1`, op 1–4:
  - Compute the result from A and B and latch it into pending.
  - Set `cnt` to the op's cycle count.
  - Set `busy` to 1.
- Results:
  - mult: signed 64-bit product; {HI,LO} = A×B.
  - multu: unsigned 64-bit product.
  - div: signed. LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - divu: unsigned. LO = quotient, HI = remainder.
- Divide by zero (B=0, div or divu):
  - Runs the full DIV_CYCLES.
  - Commits nothing; HI and LO keep their old values.
- div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- RUN: `cnt` decrements every cycle. On the edge where `cnt`==1:
  - HI and LO take the pending values.
  - `busy` goes to 0.
  - `cnt` goes to 0.
- IDLE, `start=1`, op 5 (mthi): `HI<=A` on that edge. `busy` stays 0.
- IDLE, `start=1`, op 6 (mtlo): `LO<=A` on that edge. `busy` stays 0.
- `start=1` with op 0 or 7: ignored.
- `start=1` while `busy=1`: ignored entirely, including mthi/mtlo.
  - The hazard unit guarantees this cannot happen.
  - The bench checks that the in-flight result is not corrupted.
- `HI`/`LO` are registered outputs only. No combinational bypass of a pending result; `mfhi`/`mflo` are stalled by the hazard unit until `busy=0`.

## Timing
- Let cycle 0 be the cycle in which `start=1` with a mult/div op.
  - `busy=1` in cycles 1..N, where N = MULT_CYCLES or DIV_CYCLES.
  - `busy=0` and the new HI/LO are visible from cycle N+1.
- mthi/mtlo issued in cycle 0: the new value is visible in cycle 1.
- Back-to-back: a new `start` is accepted in cycle N+1. That is the earliest cycle an `mfhi` in E reads the committed value.
- The stall seen by D is `start|busy`: N+1 cycles per mult/div. This unit does not generate it.
- `reset` asserted in any RUN cycle k: from the next cycle `busy=0`, `HI=LO=0`. No late commit occurs.
- `reset` and `start` in the same cycle: reset wins.
- After reset, `start` is accepted in the first cycle with `reset=0`.

## Test plan
- Reset, then mult with A=0xFFFFFFFD (−3), B=5 in cycle 0:
  - `busy`=1 in cycles 1–5.
  - Cycle 6: `busy`=0, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - HI and LO are unchanged (0) during cycles 1–5.
- multu with A=0xFFFFFFFF, B=2: HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div with A=0xFFFFFFF9 (−7), B=2: after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu with A=7, B=0, HI/LO preset by mthi 0x11 and mtlo 0x22:
  - mthi 0x11 visible the next cycle with `busy` never rising.
  - `busy` is 1 for 10 cycles.
  - HI=0x11 and LO=0x22 afterwards.
- mult 3×4 started, then `start`+mtlo A=0xAB in busy cycle 2:
  - The mtlo is ignored.
  - Final HI=0, LO=0xC.
  - Next, reset asserted in busy cycle 3 of a divu 100/3: next cycle `busy`=0, HI=LO=0, no commit later.
